// File: rtl/cia_tod_ext.sv
// CIA time-of-day counter: 24-bit binary (8520) or BCD clock (6526) with alarm,
// read latch and one-shot alarm interrupt.
module cia_tod_ext #(
   parameter bit          BCD_MODE  = 1'b0,
   parameter logic [23:0] ALARM_RST = 24'hFFFFFF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clk7_en,
   input  logic       wr,
   input  logic       tlo,
   input  logic       tme,
   input  logic       thi,
   input  logic       thr,
   input  logic       tcr,
   input  logic [7:0] data_in,
   output logic [7:0] data_out,
   input  logic       count,
   input  logic       tick50,
   output logic       irq
);

   // Byte 0 tenths/low, 1 sec/mid, 2 min/high, 3 hours (BCD only).
   localparam logic [31:0] MASK    = BCD_MODE ? 32'h9FFF_FF0F : 32'h00FF_FFFF;
   localparam logic [31:0] TOD_RST = BCD_MODE ? 32'h0100_0000 : 32'h0000_0000;
   localparam logic [31:0] ALM_RST = ({8'hFF, ALARM_RST}) & MASK;
   localparam int          TOP     = BCD_MODE ? 3 : 2;

   logic [31:0] tod_q, tod_d, alarm_q, alarm_d, latch_q;
   logic [2:0]  pre_q, pre_d;
   logic        crb7_q, ena_q, ena_d, frozen_q, frozen_d, match_q, irq_q;
   logic [3:0]  we;
   logic        tod_wr, tick, frz_rd, rel_rd, match;
   logic [2:0]  pre_term;

   function automatic logic [4:0] dig(input logic [3:0] v, input logic [3:0] term);
      if (v == term) return 5'h10;
      return {1'b0, v + 4'd1};
   endfunction

   function automatic logic [31:0] bcd_inc(input logic [31:0] t);
      logic [31:0] r;
      logic        c;
      logic [4:0]  h;
      r = t;
      h = t[28:24];
      {c, r[3:0]} = dig(t[3:0], 4'd9);
      if (c) {c, r[11:8]}  = dig(t[11:8], 4'd9);
      if (c) {c, r[15:12]} = dig(t[15:12], 4'd5);
      if (c) {c, r[19:16]} = dig(t[19:16], 4'd9);
      if (c) {c, r[23:20]} = dig(t[23:20], 4'd5);
      if (c) begin
         // 11->12 flips AM/PM; 12->01 keeps it.
         if (h == 5'h11) begin
            r[28:24] = 5'h12;
            r[31]    = ~t[31];
         end else if (h == 5'h12) r[28:24] = 5'h01;
         else if (h[3:0] == 4'h9) r[28:24] = 5'h10;
         else r[27:24] = h[3:0] + 4'd1;
      end
      return r;
   endfunction

   assign we       = {thr & BCD_MODE, thi, tme, tlo} & {4{wr}};
   assign tod_wr   = (|we) & ~crb7_q;
   assign tick     = count & ena_q & ~tod_wr;
   assign frz_rd   = ~wr & (BCD_MODE ? thr : thi) & ~crb7_q;
   assign rel_rd   = ~wr & tlo;
   assign match    = (tod_q == alarm_q);
   assign pre_term = tick50 ? 3'd4 : 3'd5;
   assign irq      = irq_q;

   always_comb begin
      tod_d    = tod_q;
      alarm_d  = alarm_q;
      pre_d    = pre_q;
      ena_d    = ena_q;
      frozen_d = frozen_q;
      if (tick) begin
         if (BCD_MODE) begin
            if (pre_q == pre_term) begin
               pre_d = 3'd0;
               tod_d = bcd_inc(tod_q) & MASK;
            end else pre_d = pre_q + 3'd1;
         end else tod_d = {8'h00, tod_q[23:0] + 24'd1};
      end
      for (int b = 0; b < 4; b++) begin
         if (we[b]) begin
            if (crb7_q) alarm_d[b*8 +: 8] = data_in & MASK[b*8 +: 8];
            else        tod_d[b*8 +: 8]   = data_in & MASK[b*8 +: 8];
         end
      end
      if (tod_wr && we[0])   pre_d = 3'd0;
      if (tod_wr && we[0])   ena_d = 1'b1;
      if (tod_wr && we[TOP]) ena_d = 1'b0;
      if (frz_rd) frozen_d = 1'b1;
      if (rel_rd) frozen_d = 1'b0;
   end

   always_comb begin
      data_out = 8'h00;
      if (!wr) begin
         if (tlo)      data_out = latch_q[7:0];
         else if (tme) data_out = latch_q[15:8];
         else if (thi) data_out = latch_q[23:16];
         else if (thr) data_out = latch_q[31:24];
         else if (tcr) data_out = {crb7_q, 7'b0};
      end
   end

   always_ff @(posedge clk) begin
      if (clk7_en) begin
         if (reset) begin
            tod_q    <= TOD_RST;
            alarm_q  <= ALM_RST;
            latch_q  <= TOD_RST;
            pre_q    <= 3'd0;
            ena_q    <= 1'b1;
            frozen_q <= 1'b0;
            crb7_q   <= 1'b0;
            match_q  <= 1'b0;
            irq_q    <= 1'b0;
         end else begin
            tod_q    <= tod_d;
            alarm_q  <= alarm_d;
            pre_q    <= pre_d;
            ena_q    <= ena_d;
            frozen_q <= frozen_d;
            // Freezing read keeps the value just returned for the top byte.
            if (!frozen_q && !frz_rd) latch_q <= tod_q;
            if (wr && tcr) crb7_q <= data_in[7];
            match_q  <= match;
            irq_q    <= match & ~match_q;
         end
      end
   end

endmodule

// File: tb/tb_cia_tod_ext.sv
// Bench for cia_tod_ext: binary and BCD instances on a shared bus, table plus
// hand sequences, expectations queued at drive time and checked on negedge.
module tb_cia_tod_ext;

   logic       clk = 1'b0;
   logic       reset, clk7_en, wr, tlo, tme, thi, thr, tcr, count, tick50;
   logic [7:0] data_in, dout_b, dout_c;
   logic       irq_b, irq_c;
   bit         done = 1'b0;

   always #5 clk = ~clk;

   cia_tod_ext #(.BCD_MODE(1'b0)) u_bin (
      .clk(clk), .reset(reset), .clk7_en(clk7_en), .wr(wr), .tlo(tlo), .tme(tme),
      .thi(thi), .thr(thr), .tcr(tcr), .data_in(data_in), .data_out(dout_b),
      .count(count), .tick50(tick50), .irq(irq_b));

   cia_tod_ext #(.BCD_MODE(1'b1)) u_bcd (
      .clk(clk), .reset(reset), .clk7_en(clk7_en), .wr(wr), .tlo(tlo), .tme(tme),
      .thi(thi), .thr(thr), .tcr(tcr), .data_in(data_in), .data_out(dout_c),
      .count(count), .tick50(tick50), .irq(irq_c));

   localparam logic [4:0] NO = 5'd0, LO = 5'd1, ME = 5'd2, HI = 5'd4, HR = 5'd8, CR = 5'd16;
   // Check kinds: 1 bin data_out, 2 bcd data_out, 3 bin irq, 4 bcd irq.
   typedef struct {
      logic       w;
      logic [4:0] s;
      logic [7:0] d;
      logic       c;
      int         k;
      logic [7:0] e;
   } vec_t;
   typedef struct {
      int         k;
      logic [7:0] e;
      string      nm;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];
   int   n_chk = 0;
   int   n_pass = 0;

   always @(negedge clk) begin
      while (sb.size() > 0) begin
         exp_t       x;
         logic [7:0] a;
         x = sb.pop_front();
         case (x.k)
            1:       a = dout_b;
            2:       a = dout_c;
            3:       a = {7'b0, irq_b};
            default: a = {7'b0, irq_c};
         endcase
         n_chk++;
         if (a === x.e) n_pass++;
         else $display("FAIL %s: got %h want %h", x.nm, a, x.e);
      end
   end

   initial begin
      #200000;
      if (!done) begin
         $display("FAIL timeout: bench did not finish");
         $finish;
      end
   end

   function automatic void add(input logic w, input logic [4:0] s, input logic [7:0] d,
                               input logic c, input int k, input logic [7:0] e);
      vec_t v;
      v.w = w; v.s = s; v.d = d; v.c = c; v.k = k; v.e = e;
      tbl.push_back(v);
   endfunction

   task automatic cyc(input logic w, input logic [4:0] s, input logic [7:0] d, input logic c,
                      input int k, input logic [7:0] e, input string nm);
      wr = w;
      {tcr, thr, thi, tme, tlo} = s;
      data_in = d;
      count = c;
      if (k != 0) sb.push_back('{k, e, nm});
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [4:0] s, input logic [7:0] e, input string nm);
      cyc(1'b0, s, 8'h00, 1'b0, 2, e, nm);
   endtask
   task automatic wrt(input logic [4:0] s, input logic [7:0] d);
      cyc(1'b1, s, d, 1'b0, 0, 8'h00, "");
   endtask
   task automatic tk(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, NO, 8'h00, 1'b1, 0, 8'h00, "");
   endtask
   task automatic idle();
      cyc(1'b0, NO, 8'h00, 1'b0, 0, 8'h00, "");
   endtask
   task automatic irqc(input logic [7:0] e, input string nm);
      cyc(1'b0, NO, 8'h00, 1'b0, 4, e, nm);
   endtask
   task automatic do_reset();
      reset = 1'b1;
      idle();
      idle();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b0; clk7_en = 1'b1; wr = 1'b0; count = 1'b0; tick50 = 1'b0;
      {tcr, thr, thi, tme, tlo} = NO; data_in = 8'h00;

      // Binary-mode vectors: {wr, sel, data, count, kind, expected}
      add(0, LO, 8'h00, 0, 1, 8'h00);   // reset low byte
      add(0, CR, 8'h00, 0, 1, 8'h00);   // crb7 reset
      add(0, HR, 8'h00, 0, 1, 8'h00);   // thr reads 0 in binary
      add(1, CR, 8'h80, 0, 0, 8'h00);
      add(0, CR, 8'h00, 0, 1, 8'h80);
      add(1, HI, 8'h00, 0, 0, 8'h00);   // alarm = 000005
      add(1, ME, 8'h00, 0, 0, 8'h00);
      add(1, LO, 8'h05, 0, 0, 8'h00);
      add(1, CR, 8'h00, 0, 1, 8'h00);   // data_out 0 on write
      add(1, HI, 8'h00, 0, 0, 8'h00);   // tod = 000003
      add(1, ME, 8'h00, 0, 0, 8'h00);
      add(1, LO, 8'h03, 0, 0, 8'h00);
      add(0, NO, 8'h00, 1, 0, 8'h00);
      add(0, NO, 8'h00, 1, 0, 8'h00);
      add(0, NO, 8'h00, 0, 3, 8'h00);
      add(0, NO, 8'h00, 0, 3, 8'h01);   // alarm pulse
      add(0, NO, 8'h00, 0, 3, 8'h00);
      add(0, NO, 8'h00, 0, 3, 8'h00);   // sustained match, no repeat
      add(0, LO, 8'h00, 0, 1, 8'h05);
      add(1, HI, 8'hFF, 0, 0, 8'h00);   // wrap test
      add(1, ME, 8'hFF, 0, 0, 8'h00);
      add(1, LO, 8'hFF, 0, 0, 8'h00);
      add(0, NO, 8'h00, 1, 0, 8'h00);
      add(0, NO, 8'h00, 0, 3, 8'h00);
      add(0, LO, 8'h00, 0, 1, 8'h00);
      add(0, ME, 8'h00, 0, 1, 8'h00);
      add(0, HI, 8'h00, 0, 1, 8'h00);
      add(0, LO, 8'h00, 0, 1, 8'h00);
      add(1, HI, 8'h12, 0, 0, 8'h00);   // write-stop
      for (int i = 0; i < 10; i++) add(0, NO, 8'h00, 1, 0, 8'h00);
      add(0, NO, 8'h00, 0, 0, 8'h00);
      add(0, ME, 8'h00, 0, 1, 8'h00);
      add(0, HI, 8'h00, 0, 1, 8'h12);
      add(0, LO, 8'h00, 0, 1, 8'h00);
      add(1, LO, 8'h40, 0, 0, 8'h00);
      add(0, NO, 8'h00, 1, 0, 8'h00);
      add(0, NO, 8'h00, 0, 0, 8'h00);
      add(0, LO, 8'h00, 0, 1, 8'h41);
      add(1, LO, 8'h80, 1, 0, 8'h00);   // tick dropped by tlo write
      add(0, NO, 8'h00, 0, 0, 8'h00);
      add(0, LO, 8'h00, 0, 1, 8'h80);
      add(1, ME, 8'h33, 1, 0, 8'h00);   // tick dropped by tme write
      add(0, NO, 8'h00, 0, 0, 8'h00);
      add(0, LO, 8'h00, 0, 1, 8'h80);
      add(0, ME, 8'h00, 0, 1, 8'h33);
      add(0, NO, 8'h00, 0, 1, 8'h00);

      do_reset();
      if (irq_b !== 1'b0 || irq_c !== 1'b0 || dout_b !== 8'h00 || dout_c !== 8'h00)
         $display("FAIL reset_state: irq_b=%b irq_c=%b dout_b=%h dout_c=%h",
                  irq_b, irq_c, dout_b, dout_c);
      for (int i = 0; i < tbl.size(); i++)
         cyc(tbl[i].w, tbl[i].s, tbl[i].d, tbl[i].c, tbl[i].k, tbl[i].e,
             $sformatf("bin_vec%0d", i));

      // BCD mode
      do_reset();
      rd(LO, 8'h00, "bcd_rst_tenths");
      rd(ME, 8'h00, "bcd_rst_sec");
      rd(HI, 8'h00, "bcd_rst_min");
      rd(HR, 8'h01, "bcd_rst_hr");
      rd(CR, 8'h00, "bcd_rst_crb");
      rd(LO, 8'h00, "bcd_rst_rel");

      wrt(HR, 8'h11); wrt(HI, 8'h59); wrt(ME, 8'h59); wrt(LO, 8'h09);
      tk(6);
      idle();
      rd(LO, 8'h00, "am_pm_tenths");
      rd(ME, 8'h00, "am_pm_sec");
      rd(HI, 8'h00, "am_pm_min");
      rd(HR, 8'h92, "am_pm_hr");
      rd(LO, 8'h00, "am_pm_rel");

      wrt(HR, 8'h92); wrt(HI, 8'h59); wrt(ME, 8'h59); wrt(LO, 8'h09);
      tk(6);
      idle();
      rd(HI, 8'h00, "h12_min");
      rd(HR, 8'h81, "h12_hr");
      rd(LO, 8'h00, "h12_rel");

      idle();
      rd(HR, 8'h81, "latch_frz_hr");
      tk(66);
      rd(ME, 8'h00, "latch_held_sec");
      rd(LO, 8'h00, "latch_held_tenths");
      idle();
      rd(HR, 8'h81, "latch_new_hr");
      rd(ME, 8'h01, "latch_new_sec");
      rd(LO, 8'h01, "latch_new_tenths");

      tick50 = 1'b1;
      wrt(LO, 8'h05);
      tk(5);
      idle();
      rd(LO, 8'h06, "tick50_tenths");
      wrt(LO, 8'h0F);
      tk(5);
      idle();
      rd(ME, 8'h01, "invalid_nocarry_sec");
      rd(LO, 8'h00, "invalid_wrap_tenths");

      wrt(CR, 8'h80);
      wrt(HR, 8'h81); wrt(HI, 8'h00); wrt(ME, 8'h01); wrt(LO, 8'h00);
      irqc(8'h00, "alm_wr_irq_early");
      irqc(8'h01, "alm_wr_irq");
      irqc(8'h00, "alm_wr_irq_end");
      irqc(8'h00, "alm_wr_irq_hold");
      wrt(CR, 8'h00);
      tk(5);
      idle();
      rd(LO, 8'h01, "alm_wr_keeps_ena");

      clk7_en = 1'b0;
      tk(5);
      clk7_en = 1'b1;
      idle();
      rd(LO, 8'h01, "clk7_en_gate");

      tk(2);
      idle();
      rd(HR, 8'h81, "pre_reset_frz");
      reset = 1'b1;
      idle();
      reset = 1'b0;
      rd(HR, 8'h01, "mid_reset_hr");
      rd(LO, 8'h00, "mid_reset_tenths");
      tk(3);
      idle();
      rd(LO, 8'h00, "mid_reset_prescale");
      rd(CR, 8'h00, "mid_reset_crb");
      irqc(8'h00, "mid_reset_irq");

      @(negedge clk);
      #1;
      done = 1'b1;
      if (n_chk < 12) $display("FAIL too few checks: %0d", n_chk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
